// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message sequencer: FSM states,
// the controller power-up instruction list and the per-line DDRAM address codes.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_INIT_WAIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam int LCD_INIT_LEN = 5;
  localparam int LCD_DATA_BIT = 8;

  // function set, display on, clear, entry mode, home
  localparam logic [8:0] LCD_INIT_SEQ [LCD_INIT_LEN] =
    '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};

  localparam logic [8:0] LCD_LINE_ADDR [4] =
    '{9'h080, 9'h0C0, 9'h094, 9'h0D4};

endpackage

// File: rtl/lcd_msg_sequencer.sv
// Drives LCD_controller through init and full-screen refreshes of a message.
// Optional build macro LCD_AUTO_REFRESH_EN: a Msg_select change also requests a refresh.
//
// state        | meaning
// S_INIT       | present next power-up instruction
// S_INIT_WAIT  | wait for controller to finish an init instruction
// S_IDLE       | init complete, waiting for a refresh request
// S_ISSUE      | present next address/data instruction of the refresh
// S_WAIT       | wait for controller, then advance column/line
module lcd_msg_sequencer
  import lcd_pkg::*;
#(
  parameter int NUM_LINES = 2,
  parameter int NUM_COLS  = 16,
  parameter int NUM_MSGS  = 4,
  localparam int MSG_W    = $clog2(NUM_MSGS)
) (
  input  logic             Clock_50,
  input  logic             Resetn,
  input  logic [MSG_W-1:0] Msg_select,
  input  logic             Update_req,
  output logic [MSG_W-1:0] Char_msg,
  output logic [1:0]       Char_line,
  output logic [5:0]       Char_col,
  input  logic [7:0]       Char_code,
  output logic             LCD_start,
  output logic [8:0]       LCD_instruction,
  input  logic             LCD_done,
  output logic             Init_done,
  output logic             Busy
);

  localparam logic [5:0] LAST_COL  = 6'(NUM_COLS - 1);
  localparam logic [1:0] LAST_LINE = 2'(NUM_LINES - 1);
  localparam logic [2:0] LAST_INIT = 3'(LCD_INIT_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_init_idx, w_init_idx_nxt;
  logic [1:0]       r_line, w_line_nxt;
  logic [5:0]       r_col, w_col_nxt;
  logic             r_phase_data, w_phase_data_nxt;
  logic [MSG_W-1:0] r_msg, w_msg_nxt;
  logic             r_pending, w_pending_nxt;
  logic             r_start, w_start_nxt;
  logic [8:0]       r_instr, w_instr_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             w_done;
  logic             w_set_pending;

`ifdef LCD_AUTO_REFRESH_EN
  logic [MSG_W-1:0] r_msg_prev;
  logic             w_msg_chg;

  always_ff @(posedge Clock_50) begin
    if (!Resetn) r_msg_prev <= '0;
    else         r_msg_prev <= Msg_select;
  end

  assign w_msg_chg     = (Msg_select != r_msg_prev);
  assign w_set_pending = (Update_req && (r_state != S_IDLE)) || (w_msg_chg && r_init_done);
`else
  assign w_set_pending = Update_req && (r_state != S_IDLE);
`endif

  // LCD_done is only honoured once the start strobe has dropped
  assign w_done = LCD_done && !r_start;

  always_comb begin
    w_state_nxt      = r_state;
    w_init_idx_nxt   = r_init_idx;
    w_line_nxt       = r_line;
    w_col_nxt        = r_col;
    w_phase_data_nxt = r_phase_data;
    w_msg_nxt        = r_msg;
    w_pending_nxt    = r_pending || w_set_pending;
    w_start_nxt      = 1'b0;
    w_instr_nxt      = r_instr;
    w_init_done_nxt  = r_init_done;

    case (r_state)
      S_INIT: begin
        w_instr_nxt = LCD_INIT_SEQ[r_init_idx];
        w_start_nxt = 1'b1;
        w_state_nxt = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (w_done) begin
          if (r_init_idx == LAST_INIT) begin
            w_init_done_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_init_idx_nxt = r_init_idx + 3'd1;
            w_state_nxt    = S_INIT;
          end
        end
      end
      S_IDLE: begin
        if (Update_req || r_pending) begin
          w_pending_nxt    = 1'b0;
          w_msg_nxt        = Msg_select;
          w_line_nxt       = '0;
          w_col_nxt        = '0;
          w_phase_data_nxt = 1'b0;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_phase_data) begin
          w_instr_nxt               = {1'b0, Char_code};
          w_instr_nxt[LCD_DATA_BIT] = 1'b1;
        end else begin
          w_instr_nxt = LCD_LINE_ADDR[r_line];
        end
        w_start_nxt = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done) begin
          w_state_nxt = S_ISSUE;
          if (!r_phase_data) begin
            w_phase_data_nxt = 1'b1;
          end else if (r_col != LAST_COL) begin
            w_col_nxt = r_col + 6'd1;
          end else if (r_line != LAST_LINE) begin
            w_line_nxt       = r_line + 2'd1;
            w_col_nxt        = '0;
            w_phase_data_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      r_state      <= S_INIT;
      r_init_idx   <= '0;
      r_line       <= '0;
      r_col        <= '0;
      r_phase_data <= 1'b0;
      r_msg        <= '0;
      r_pending    <= 1'b0;
      r_start      <= 1'b0;
      r_instr      <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_init_idx   <= w_init_idx_nxt;
      r_line       <= w_line_nxt;
      r_col        <= w_col_nxt;
      r_phase_data <= w_phase_data_nxt;
      r_msg        <= w_msg_nxt;
      r_pending    <= w_pending_nxt;
      r_start      <= w_start_nxt;
      r_instr      <= w_instr_nxt;
      r_init_done  <= w_init_done_nxt;
    end
  end

  assign Char_msg        = r_msg;
  assign Char_line       = r_line;
  assign Char_col        = r_col;
  assign LCD_start       = r_start;
  assign LCD_instruction = r_instr;
  assign Init_done       = r_init_done;
  assign Busy            = (r_state != S_IDLE);

endmodule
